stream_access_ctrl: RTL and testbench
=====================================

// Module: stream_access_ctrl
// PURPOSE
//  Frame-level access controller between the AXI-Stream DMA, the upsampling core and the
//  config register file. Starts a frame when UPSTART is set, gates the input and output
//  streams, frames output (tuser/tlast), reports handshakes for the performance counters,
//  and writes UPEND to UPSTAT (addr 0) when the last output pixel leaves.
// PARAMETERS
//  CRF_DATA_WIDTH  32    config register data width
//  CRF_ADDR_WIDTH  32    config register address width
//  PIX_WIDTH       24    pixel width (RGB888)
//  SRC_W           960   input frame width, pixels
//  SRC_H           540   input frame height, lines
//  SCALE           4     upscale factor per axis; output is SRC_W*SCALE x SRC_H*SCALE
// PORTS
//  clk                  in   1               clock
//  rst_n                in   1               asynchronous reset, active-low
//  crf_ac_UPSTART       in   1               UPSTAT[0], frame start request
//  crf_ac_UPEND         in   1               UPSTAT[1], frame done flag
//  crf_ac_wbusy         in   1               CRF write port busy (PS write pending)
//  ac_crf_wrt           out  1               CRF write request
//  ac_crf_waddr         out  CRF_ADDR_WIDTH  CRF write address
//  ac_crf_wdata         out  CRF_DATA_WIDTH  CRF write data
//  ac_crf_axisi_tvalid  out  1 / ac_crf_axisi_tready out 1   input-stream handshake copy
//  ac_crf_axiso_tvalid  out  1 / ac_crf_axiso_tready out 1   output-stream handshake copy
//  ac_crf_processing    out  1               high while state==RUN
//  s_axis_tvalid/tready in/out 1, s_axis_tdata in PIX_WIDTH   source pixels from DMA
//  m_core_tvalid/tready out/in 1, m_core_tdata out PIX_WIDTH  pixels to core
//  s_core_tvalid/tready in/out 1, s_core_tdata in PIX_WIDTH   upsampled pixels from core
//  m_axis_tvalid/tready out/in 1, m_axis_tdata out PIX_WIDTH  pixels to DMA
//  m_axis_tuser         out  1               start of frame (output pixel 0)
//  m_axis_tlast         out  1               end of output line
// BEHAVIOUR
//  - Reset: state IDLE, all counters 0, every output 0 (tready/tvalid/wrt/processing/tuser/tlast).
//  - IN_TOTAL=SRC_W*SRC_H, OUT_W=SRC_W*SCALE, OUT_TOTAL=OUT_W*SRC_H*SCALE; counters 32-bit, no wrap.
//  - FSM: IDLE -> RUN when UPSTART & ~UPEND. RUN -> WREQ on the cycle the OUT_TOTAL-th
//    output handshake completes. WREQ -> DONE when ac_crf_wrt & ~crf_ac_wbusy.
//    DONE -> IDLE when UPEND==0 (PS cleared UPSTAT).
//  - Abort: UPSTART==0 in RUN -> IDLE next cycle, counters cleared, no UPEND write.
//  - Input path (zero latency, combinational): m_core_tvalid=s_axis_tvalid&in_en,
//    s_axis_tready=m_core_tready&in_en, tdata passes; in_en = RUN & in_cnt<IN_TOTAL.
//    Extra input beyond IN_TOTAL is back-pressured (tready 0), never dropped.
//  - Output path (zero latency): m_axis_tvalid=s_core_tvalid&RUN, s_core_tready=m_axis_tready&RUN.
//    Column/row counters advance on handshake; tuser=(col==0&row==0), tlast=(col==OUT_W-1),
//    both valid only with m_axis_tvalid, 0 otherwise.
//  - axisi_* = s_axis_tvalid/s_axis_tready as seen at the ports; axiso_* = m_axis pair.
//  - WREQ: ac_crf_wrt=1, waddr=0, wdata=32'h2 (UPEND=1, UPSTART=0), held stable while wbusy.
//    processing=0 from WREQ onward so CRF counters freeze at final values.
//  - IDLE/DONE: all stream readies/valids 0; upstream data held by DMA.
//  - Reset mid-frame: immediate return to reset values; no partial UPEND write.
// STRUCTURE
//  - Shared package ac_pkg: state enum (IDLE,RUN,WREQ,DONE), CRF_UPSTAT_ADDR=0,
//    UPSTAT_START_BIT=0, UPSTAT_END_BIT=1.
//  - Sub-module frame_pixel_counter (params W,H): col/row counters, first/eol/eof flags,
//    synchronous clear; one instance for input (W=SRC_W,H=SRC_H), one for output.
// TESTING (SRC_W=4, SRC_H=2, SCALE=2: IN_TOTAL=8, OUT_W=8, OUT_TOTAL=32)
//  1 UPSTART=1, stream 8 in / 32 out, tready always 1 -> tuser on beat 0, tlast on beats
//    7,15,23,31; wrt=1 waddr=0 wdata=2 cycle after beat 31; processing high 32+ cycles.
//  2 Offer 10 input beats -> exactly 8 accepted, s_axis_tready=0 after 8th.
//  3 Hold wbusy=1 for 5 cycles in WREQ -> wrt, waddr, wdata stable; DONE on first wbusy=0.
//  4 Clear UPSTART after 3 output beats -> IDLE next cycle, no wrt, next frame tuser on beat 0.
//  5 Random m_axis_tready (50%) -> no lost/duplicated beats, tlast count=4, UPEND write once.
//  6 Assert rst_n=0 mid-RUN -> all outputs 0 asynchronously; restart frame completes normally.

Source files
------------

// File: rtl/ac_pkg.sv
// ac_pkg: shared constants for the stream access controller.
//   - Controller state encoding (IDLE, RUN, WREQ, DONE).
//   - UPSTAT register address and bit positions in the config register file.
package ac_pkg;

  typedef logic [1:0] ac_state_t;

  localparam ac_state_t ST_IDLE = 2'd0;
  localparam ac_state_t ST_RUN  = 2'd1;
  localparam ac_state_t ST_WREQ = 2'd2;
  localparam ac_state_t ST_DONE = 2'd3;

  localparam int unsigned CRF_UPSTAT_ADDR   = 0;
  localparam int unsigned UPSTAT_START_BIT  = 0;
  localparam int unsigned UPSTAT_END_BIT    = 1;

endpackage

// File: rtl/frame_pixel_counter.sv
// frame_pixel_counter: column/row position tracker for a W x H pixel frame.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_clr        synchronous clear back to pixel 0
//   i_adv        advance by one pixel (a completed handshake)
//   o_first      current position is pixel 0 of the frame
//   o_eol        current position is the last column of a line
//   o_eof        current position is the last pixel of the frame
//   o_done       all W*H pixels have been counted; further advances are ignored
module frame_pixel_counter #(
  parameter int unsigned W = 4,
  parameter int unsigned H = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_adv,
  output logic o_first,
  output logic o_eol,
  output logic o_eof,
  output logic o_done
);

  localparam logic [31:0] W_LAST = 32'(W - 1);
  localparam logic [31:0] H_LAST = 32'(H - 1);

  logic [31:0] r_col;
  logic [31:0] r_row;
  logic        r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_done <= 1'b0;
    end else if (i_clr) begin
      r_col  <= '0;
      r_row  <= '0;
      r_done <= 1'b0;
    end else if (i_adv && !r_done) begin
      if (r_col == W_LAST) begin
        r_col <= '0;
        if (r_row == H_LAST) begin
          r_row  <= '0;
          r_done <= 1'b1;
        end else begin
          r_row <= r_row + 32'd1;
        end
      end else begin
        r_col <= r_col + 32'd1;
      end
    end
  end

  assign o_first = (r_col == '0) && (r_row == '0) && !r_done;
  assign o_eol   = (r_col == W_LAST) && !r_done;
  assign o_eof   = (r_col == W_LAST) && (r_row == H_LAST) && !r_done;
  assign o_done  = r_done;

endmodule

// File: rtl/stream_access_ctrl.sv
// stream_access_ctrl: frame-level access controller between the AXI-Stream DMA, the
// upsampling core and the config register file (CRF).
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   crf_ac_UPSTART/UPEND            UPSTAT[0]/[1] as held in the CRF
//   crf_ac_wbusy                    CRF write port busy
//   ac_crf_wrt/waddr/wdata          CRF write request (UPEND write at end of frame)
//   ac_crf_axisi_*/axiso_*          handshake copies for the performance counters
//   ac_crf_processing               high while a frame is running
//   s_axis_*  -> m_core_*           source pixels DMA -> core, gated to SRC_W*SRC_H beats
//   s_core_*  -> m_axis_*           upsampled pixels core -> DMA, framed with tuser/tlast
module stream_access_ctrl
  import ac_pkg::*;
#(
  parameter int unsigned CRF_DATA_WIDTH = 32,
  parameter int unsigned CRF_ADDR_WIDTH = 32,
  parameter int unsigned PIX_WIDTH      = 24,
  parameter int unsigned SRC_W          = 960,
  parameter int unsigned SRC_H          = 540,
  parameter int unsigned SCALE          = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      crf_ac_UPSTART,
  input  logic                      crf_ac_UPEND,
  input  logic                      crf_ac_wbusy,
  output logic                      ac_crf_wrt,
  output logic [CRF_ADDR_WIDTH-1:0] ac_crf_waddr,
  output logic [CRF_DATA_WIDTH-1:0] ac_crf_wdata,
  output logic                      ac_crf_axisi_tvalid,
  output logic                      ac_crf_axisi_tready,
  output logic                      ac_crf_axiso_tvalid,
  output logic                      ac_crf_axiso_tready,
  output logic                      ac_crf_processing,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [PIX_WIDTH-1:0]      s_axis_tdata,
  output logic                      m_core_tvalid,
  input  logic                      m_core_tready,
  output logic [PIX_WIDTH-1:0]      m_core_tdata,
  input  logic                      s_core_tvalid,
  output logic                      s_core_tready,
  input  logic [PIX_WIDTH-1:0]      s_core_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [PIX_WIDTH-1:0]      m_axis_tdata,
  output logic                      m_axis_tuser,
  output logic                      m_axis_tlast
);

  localparam int unsigned OUT_W = SRC_W * SCALE;
  localparam int unsigned OUT_H = SRC_H * SCALE;

  ac_state_t r_state;
  ac_state_t w_state_nxt;

  logic w_run;
  logic w_wreq;
  logic w_clr;
  logic w_in_en;
  logic w_out_en;
  logic w_in_hs;
  logic w_out_hs;
  logic w_in_first;
  logic w_in_eol;
  logic w_in_eof;
  logic w_in_done;
  logic w_out_first;
  logic w_out_eol;
  logic w_out_eof;
  logic w_out_done;
  logic w_unused;

  assign w_run  = (r_state == ST_RUN);
  assign w_wreq = (r_state == ST_WREQ);
  // Counters only hold a position while a frame is running; any other state restarts them.
  assign w_clr  = !w_run;

  // Input path: pass-through, closed once the whole source frame has been accepted so
  // surplus beats are back-pressured rather than dropped.
  assign w_in_en       = w_run && !w_in_done;
  assign m_core_tvalid = s_axis_tvalid && w_in_en;
  assign s_axis_tready = m_core_tready && w_in_en;
  assign m_core_tdata  = s_axis_tdata;
  assign w_in_hs       = s_axis_tvalid && s_axis_tready;

  // Output path: pass-through while running.
  assign w_out_en      = w_run && !w_out_done;
  assign m_axis_tvalid = s_core_tvalid && w_out_en;
  assign s_core_tready = m_axis_tready && w_out_en;
  assign m_axis_tdata  = s_core_tdata;
  assign w_out_hs      = m_axis_tvalid && m_axis_tready;
  assign m_axis_tuser  = m_axis_tvalid && w_out_first;
  assign m_axis_tlast  = m_axis_tvalid && w_out_eol;

  frame_pixel_counter #(
    .W (SRC_W),
    .H (SRC_H)
  ) u_in_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_adv   (w_in_hs),
    .o_first (w_in_first),
    .o_eol   (w_in_eol),
    .o_eof   (w_in_eof),
    .o_done  (w_in_done)
  );

  frame_pixel_counter #(
    .W (OUT_W),
    .H (OUT_H)
  ) u_out_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_clr),
    .i_adv   (w_out_hs),
    .o_first (w_out_first),
    .o_eol   (w_out_eol),
    .o_eof   (w_out_eof),
    .o_done  (w_out_done)
  );

  // The input side only needs to know when the source frame is complete.
  assign w_unused = w_in_first ^ w_in_eol ^ w_in_eof;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (crf_ac_UPSTART && !crf_ac_UPEND) w_state_nxt = ST_RUN;
      ST_RUN: begin
        // Abort wins over frame completion: no UPEND write for an abandoned frame.
        if (!crf_ac_UPSTART)           w_state_nxt = ST_IDLE;
        else if (w_out_hs && w_out_eof) w_state_nxt = ST_WREQ;
      end
      ST_WREQ: if (!crf_ac_wbusy) w_state_nxt = ST_DONE;
      ST_DONE: if (!crf_ac_UPEND) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // UPEND=1, UPSTART=0 written to UPSTAT; held from state so it is stable under wbusy.
  always_comb begin
    ac_crf_wdata = '0;
    if (w_wreq) begin
      ac_crf_wdata[UPSTAT_END_BIT]   = 1'b1;
      ac_crf_wdata[UPSTAT_START_BIT] = 1'b0;
    end
  end

  assign ac_crf_wrt   = w_wreq;
  assign ac_crf_waddr = CRF_ADDR_WIDTH'(CRF_UPSTAT_ADDR);

  assign ac_crf_processing   = w_run;
  assign ac_crf_axisi_tvalid = s_axis_tvalid;
  assign ac_crf_axisi_tready = s_axis_tready;
  assign ac_crf_axiso_tvalid = m_axis_tvalid;
  assign ac_crf_axiso_tready = m_axis_tready && w_run;

endmodule

// File: tb/tb_stream_access_ctrl.sv
// tb_stream_access_ctrl: self-checking bench for stream_access_ctrl with a 4x2 source
// frame upscaled by 2 (8 input beats, 8x4 = 32 output beats). Expected values come from
// a frame-level model (beat counts and CRF register contents).
module tb_stream_access_ctrl;

  localparam int unsigned SW        = 4;
  localparam int unsigned SH        = 2;
  localparam int unsigned SC        = 2;
  localparam int unsigned IN_TOTAL  = SW * SH;
  localparam int unsigned OUT_W     = SW * SC;
  localparam int unsigned OUT_TOTAL = OUT_W * SH * SC;
  localparam int          GUARD     = 1000;

  logic        clk;
  logic        rst_n;
  logic        crf_ac_UPSTART, crf_ac_UPEND, crf_ac_wbusy;
  logic        ac_crf_wrt;
  logic [31:0] ac_crf_waddr, ac_crf_wdata;
  logic        ac_crf_axisi_tvalid, ac_crf_axisi_tready;
  logic        ac_crf_axiso_tvalid, ac_crf_axiso_tready;
  logic        ac_crf_processing;
  logic        s_axis_tvalid, s_axis_tready;
  logic [23:0] s_axis_tdata;
  logic        m_core_tvalid, m_core_tready;
  logic [23:0] m_core_tdata;
  logic        s_core_tvalid, s_core_tready;
  logic [23:0] s_core_tdata;
  logic        m_axis_tvalid, m_axis_tready;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tuser, m_axis_tlast;

  stream_access_ctrl #(
    .CRF_DATA_WIDTH (32),
    .CRF_ADDR_WIDTH (32),
    .PIX_WIDTH      (24),
    .SRC_W          (SW),
    .SRC_H          (SH),
    .SCALE          (SC)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .crf_ac_UPSTART      (crf_ac_UPSTART),
    .crf_ac_UPEND        (crf_ac_UPEND),
    .crf_ac_wbusy        (crf_ac_wbusy),
    .ac_crf_wrt          (ac_crf_wrt),
    .ac_crf_waddr        (ac_crf_waddr),
    .ac_crf_wdata        (ac_crf_wdata),
    .ac_crf_axisi_tvalid (ac_crf_axisi_tvalid),
    .ac_crf_axisi_tready (ac_crf_axisi_tready),
    .ac_crf_axiso_tvalid (ac_crf_axiso_tvalid),
    .ac_crf_axiso_tready (ac_crf_axiso_tready),
    .ac_crf_processing   (ac_crf_processing),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tready       (s_axis_tready),
    .s_axis_tdata        (s_axis_tdata),
    .m_core_tvalid       (m_core_tvalid),
    .m_core_tready       (m_core_tready),
    .m_core_tdata        (m_core_tdata),
    .s_core_tvalid       (s_core_tvalid),
    .s_core_tready       (s_core_tready),
    .s_core_tdata        (s_core_tdata),
    .m_axis_tvalid       (m_axis_tvalid),
    .m_axis_tready       (m_axis_tready),
    .m_axis_tdata        (m_axis_tdata),
    .m_axis_tuser        (m_axis_tuser),
    .m_axis_tlast        (m_axis_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Frame-level model: CRF UPSTAT bits plus accepted/emitted beat counts.
  bit m_start, m_end;
  bit m_run, m_wreq, m_done;
  int m_in, m_out;

  // Observed per-frame totals, counted from DUT outputs.
  int o_in, o_tlast, o_tuser, o_wr, o_proc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wrt"}, ac_crf_wrt, 0);
    chk({tag, "_wdata"}, ac_crf_wdata, 0);
    chk({tag, "_waddr"}, ac_crf_waddr, 0);
    chk({tag, "_proc"}, ac_crf_processing, 0);
    chk({tag, "_s_tready"}, s_axis_tready, 0);
    chk({tag, "_c_tvalid"}, m_core_tvalid, 0);
    chk({tag, "_c_tready"}, s_core_tready, 0);
    chk({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_tuser"}, m_axis_tuser, 0);
    chk({tag, "_tlast"}, m_axis_tlast, 0);
    chk({tag, "_axisi_rdy"}, ac_crf_axisi_tready, 0);
    chk({tag, "_axiso"}, {ac_crf_axiso_tvalid, ac_crf_axiso_tready}, 0);
  endtask

  // One clock: drive, check combinational outputs against the model, step the model.
  task automatic cycle(input bit sv, input bit ctr, input bit cv, input bit mtr, input bit wb);
    bit e_in_en, e_out_en, in_hs, out_hs;
    s_axis_tvalid  = sv;
    s_axis_tdata   = 24'($urandom);
    m_core_tready  = ctr;
    s_core_tvalid  = cv;
    s_core_tdata   = 24'($urandom);
    m_axis_tready  = mtr;
    crf_ac_wbusy   = wb;
    crf_ac_UPSTART = m_start;
    crf_ac_UPEND   = m_end;
    #1;
    e_in_en  = m_run && (m_in < int'(IN_TOTAL));
    e_out_en = m_run;
    chk("core_tvalid", m_core_tvalid, sv & e_in_en);
    chk("s_tready", s_axis_tready, ctr & e_in_en);
    chk("core_tdata", m_core_tdata, s_axis_tdata);
    chk("m_tvalid", m_axis_tvalid, cv & e_out_en);
    chk("core_tready", s_core_tready, mtr & e_out_en);
    chk("m_tdata", m_axis_tdata, s_core_tdata);
    chk("tuser", m_axis_tuser, cv && e_out_en && m_out == 0);
    chk("tlast", m_axis_tlast, cv && e_out_en && (m_out % OUT_W) == OUT_W - 1);
    chk("wrt", ac_crf_wrt, m_wreq);
    chk("waddr", ac_crf_waddr, 0);
    chk("wdata", ac_crf_wdata, m_wreq ? 64'h2 : 64'h0);
    chk("processing", ac_crf_processing, m_run);
    chk("axisi", {ac_crf_axisi_tvalid, ac_crf_axisi_tready}, {sv, ctr & e_in_en});
    chk("axiso", {ac_crf_axiso_tvalid, ac_crf_axiso_tready}, {cv & e_out_en, mtr & e_out_en});
    if (sv && s_axis_tready) o_in++;
    if (m_axis_tvalid && mtr && m_axis_tlast) o_tlast++;
    if (m_axis_tvalid && mtr && m_axis_tuser) o_tuser++;
    if (ac_crf_wrt && !wb) o_wr++;
    if (ac_crf_processing) o_proc++;
    in_hs  = sv && ctr && e_in_en;
    out_hs = cv && mtr && e_out_en;
    @(posedge clk);
    if (m_run) begin
      if (!m_start) begin
        m_run = 0; m_in = 0; m_out = 0;
      end else begin
        if (in_hs) m_in++;
        if (out_hs) m_out++;
        if (m_out == int'(OUT_TOTAL)) begin
          m_run = 0; m_wreq = 1; m_in = 0; m_out = 0;
        end
      end
    end else if (m_wreq) begin
      if (!wb) begin
        m_wreq = 0; m_done = 1; m_start = 0; m_end = 1;  // CRF takes the UPEND write
      end
    end else if (m_done) begin
      if (!m_end) m_done = 0;
    end else if (m_start && !m_end) begin
      m_run = 1;
    end
    #1;
  endtask

  // Run one frame request. wb_hold: wbusy cycles in WREQ; abort_at: output beat count at
  // which UPSTART is dropped (-1 = never); rnd: randomised valids/readies.
  task automatic frame(input int wb_hold, input int abort_at, input bit rnd, input string tag);
    int busy = wb_hold;
    int guard = 0;
    bit aborted = 0;
    bit sv, ctr, cv, mtr, wb;
    o_in = 0; o_tlast = 0; o_tuser = 0; o_wr = 0; o_proc = 0;
    m_start = 1;
    while (!m_done && !(aborted && !m_run) && guard < GUARD) begin
      sv  = rnd ? 1'($urandom) : 1'b1;
      ctr = rnd ? 1'($urandom) : 1'b1;
      cv  = rnd ? 1'($urandom) : 1'b1;
      mtr = rnd ? 1'($urandom) : 1'b1;
      wb  = 1'b0;
      if (m_wreq && busy > 0) begin
        wb = 1'b1;
        busy--;
      end
      if (abort_at >= 0 && m_run && m_out == abort_at) begin
        m_start = 0;
        aborted = 1;
      end
      cycle(sv, ctr, cv, mtr, wb);
      guard++;
    end
    chk({tag, "_bound"}, guard < GUARD, 1);
    if (aborted) begin
      chk({tag, "_abort_no_wr"}, o_wr, 0);
      chk({tag, "_abort_tuser"}, o_tuser, 1);
      cycle(1, 1, 1, 1, 0);
    end else begin
      chk({tag, "_wr_once"}, o_wr, 1);
      chk({tag, "_tlast_cnt"}, o_tlast, SH * SC);
      chk({tag, "_tuser_cnt"}, o_tuser, 1);
      chk({tag, "_in_cnt"}, o_in, IN_TOTAL);
      chk({tag, "_proc_ge"}, o_proc >= int'(OUT_TOTAL), 1);
      m_end = 0;  // PS clears UPSTAT
      cycle(1, 1, 1, 1, 0);
      cycle(1, 1, 1, 1, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    crf_ac_UPSTART = 0; crf_ac_UPEND = 0; crf_ac_wbusy = 0;
    s_axis_tvalid = 0; s_axis_tdata = '0; m_core_tready = 0;
    s_core_tvalid = 0; s_core_tdata = '0; m_axis_tready = 0;
    m_start = 0; m_end = 0; m_run = 0; m_wreq = 0; m_done = 0; m_in = 0; m_out = 0;
    #2;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1, 1, 1, 1, 0);  // idle with no request: everything closed

    // Full frame, ready always high; 10+ input beats offered, only 8 taken.
    frame(0, -1, 0, "t1");
    // wbusy held for 5 cycles in WREQ.
    frame(5, -1, 0, "t3");
    // Abort after 3 output beats, then a clean frame.
    frame(0, 3, 0, "t4a");
    frame(0, -1, 0, "t4b");
    // Randomised handshakes.
    for (int i = 0; i < 3; i++) frame(i, -1, 1, "t5");

    // Reset in the middle of a running frame.
    m_start = 1;
    repeat (10) cycle(1, 1, 1, 1, 0);
    s_axis_tvalid = 0; s_core_tvalid = 0; m_core_tready = 1; m_axis_tready = 1;
    #1;
    chk("t6_pre_proc", ac_crf_processing, m_run);
    chk("t6_pre_rdy", s_core_tready, m_run);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    m_run = 0; m_wreq = 0; m_done = 0; m_in = 0; m_out = 0; m_start = 0; m_end = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    frame(0, -1, 1, "t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
